// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - upstream FIFO read port and downstream word stream
// Purpose: bundles the FIFO read-side handshake and the valid/ready output stream.
// Signals:
//   fifo_empty  FIFO -> reader   upstream FIFO empty flag
//   fifo_rd     reader -> FIFO   read strobe, data returns one cycle later
//   fifo_data   FIFO -> reader   read data
//   out_valid   reader -> sink   head word valid
//   out_ready   sink -> reader   sink accepts head word
//   out_data    reader -> sink   head word
//   out_last    reader -> sink   head word closes a burst
interface fifo_stream_reader_if #(
  parameter int DataWidth = 16
);
  logic                 fifo_empty;
  logic                 fifo_rd;
  logic [DataWidth-1:0] fifo_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DataWidth-1:0] out_data;
  logic                 out_last;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain stage with 3-entry skid buffer and burst framing
// Purpose: fetches words from a one-cycle-latency FIFO read port, buffers them in a
// 3-entry circular skid buffer and emits them as a valid/ready stream with out_last
// every BurstLen words, or on the last word of a drain.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   en          high = fetch and stream, low = drain then idle
//   bus         master side of fifo_stream_reader_if (FIFO read port + output stream)
//   busy        state is not IDLE
//   word_count  beats transferred since reset, wraps at 2^32
module fifo_stream_reader #(
  parameter int DataWidth = 16,
  parameter int BurstLen  = 64,
  parameter int BeatWidth = $clog2(BurstLen)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  fifo_stream_reader_if.master  bus,
  output logic                  busy,
  output logic [31:0]           word_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(BurstLen - 1);

  state_e               state_q, state_d;
  logic [1:0]           occ_q, occ_d;
  logic [1:0]           wr_ptr_q, rd_ptr_q;
  logic                 inflight_q;
  logic [DataWidth-1:0] mem0_q, mem1_q, mem2_q;
  logic [DataWidth-1:0] head;
  logic [BeatWidth-1:0] beat_q, beat_d;
  logic [31:0]          word_count_q;
  logic [2:0]           held;
  logic                 fetch, push, pop, short_last, last;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already owned by this stage: buffered plus the one still on the FIFO bus.
  // Limiting the sum to 3 is what makes buffer overflow impossible.
  assign held  = {1'b0, occ_q} + {2'b00, inflight_q};
  assign fetch = (state_q == RUN) && !bus.fifo_empty && (held < 3'd3);
  assign push  = inflight_q;
  assign pop   = bus.out_valid && bus.out_ready;

  // Closes a short final burst: draining and this is the only word left anywhere.
  assign short_last = (state_q == DRAIN) && (occ_q == 2'd1) && !inflight_q;
  assign last       = bus.out_valid && ((beat_q == LastBeat) || short_last);

  always_comb begin
    head = mem0_q;
    case (rd_ptr_q)
      2'd1:    head = mem1_q;
      2'd2:    head = mem2_q;
      default: head = mem0_q;
    endcase
  end

  assign bus.fifo_rd   = fetch;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = head;
  assign bus.out_last  = last;
  assign busy          = (state_q != IDLE);
  assign word_count    = word_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                                  state_d = RUN;
        else if (occ_q == 2'd0 && !inflight_q)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    if (state_d == IDLE && state_q != IDLE) beat_d = '0;
    else if (pop)                           beat_d = last ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      inflight_q   <= 1'b0;
      mem0_q       <= '0;
      mem1_q       <= '0;
      mem2_q       <= '0;
      beat_q       <= '0;
      word_count_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= fetch;
      beat_q     <= beat_d;
      if (push) begin
        case (wr_ptr_q)
          2'd1:    mem1_q <= bus.fifo_data;
          2'd2:    mem2_q <= bus.fifo_data;
          default: mem0_q <= bus.fifo_data;
        endcase
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q     <= ptr_next(rd_ptr_q);
        word_count_q <= word_count_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        busy;
  logic [31:0] word_count;

  fifo_stream_reader_if #(.DataWidth(16)) bus();

  fifo_stream_reader #(.DataWidth(16), .BurstLen(64)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .busy(busy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: one-cycle read latency.
  logic [15:0] fifo_mem [0:1023];
  int          f_rd;
  int          f_wr;
  logic [15:0] fd_q;

  assign bus.fifo_empty = (f_rd == f_wr);
  assign bus.fifo_data  = fd_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_rd <= 0;
      fd_q <= 16'h0;
    end else if (bus.fifo_rd && !bus.fifo_empty) begin
      fd_q <= fifo_mem[f_rd];
      f_rd <= f_rd + 1;
    end
  end

  int          tests = 0;
  int          failed = 0;
  int          cyc, first_xfer_cyc, last_xfer_cyc, reads, viol_over, viol_stable, busy_low_cnt;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [15:0] rx_data [$];
  logic        rx_last [$];

  task automatic clear_log();
    cyc = 0; first_xfer_cyc = 0; last_xfer_cyc = 0; reads = 0;
    viol_over = 0; viol_stable = 0; busy_low_cnt = 0; prev_stall = 1'b0;
    prev_data = 16'h0; prev_last = 1'b0;
    rx_data.delete(); rx_last.delete();
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.fifo_rd && (reads - rx_data.size()) >= 3) viol_over++;
    if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
      viol_stable++;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
    if (bus.out_valid && bus.out_ready) begin
      if (rx_data.size() == 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      rx_data.push_back(bus.out_data);
      rx_last.push_back(bus.out_last);
    end
    if (bus.fifo_rd && !bus.fifo_empty) reads++;
    if (!busy) busy_low_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; bus.out_ready = 1'b0; f_wr = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_log();
  endtask

  task automatic run_until(input int n, input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      if (rx_data.size() >= n) begin ok = 1'b1; break; end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic drain_idle(output bit ok, output int idle_cyc);
    en = 1'b0; ok = 1'b0; idle_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) begin ok = 1'b1; idle_cyc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.fifo_rd !== 1'b0)   begin failed++; $display("FAIL reset_fifo_rd got %b exp 0", bus.fifo_rd); end
    tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    tests++; if (bus.out_data !== 16'h0) begin failed++; $display("FAIL reset_out_data got %h exp 0000", bus.out_data); end
    tests++; if (bus.out_last !== 1'b0)  begin failed++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
    tests++; if (busy !== 1'b0)          begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (word_count !== 32'd0)   begin failed++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
    for (int i = 0; i < 8; i++) fifo_mem[i] = 16'h5A00 + 16'(i);
    f_wr = 8; en = 1'b1; bus.out_ready = 1'b0;
    repeat (4) step();
    tests++; if (bus.out_valid !== 1'b1)  begin failed++; $display("FAIL mid_valid got %b exp 1", bus.out_valid); end
    tests++; if (bus.out_data !== 16'h5A00) begin failed++; $display("FAIL mid_data got %h exp 5a00", bus.out_data); end
    rst = 1'b0;
    #1;
    tests++; if ({bus.fifo_rd, bus.out_valid, bus.out_last, busy} !== 4'b0000)
      begin failed++; $display("FAIL async_reset_flags got %b exp 0000", {bus.fifo_rd, bus.out_valid, bus.out_last, busy}); end
    tests++; if (bus.out_data !== 16'h0) begin failed++; $display("FAIL async_reset_data got %h exp 0000", bus.out_data); end
    en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    tests++; if (busy !== 1'b0)        begin failed++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    tests++; if (word_count !== 32'd0) begin failed++; $display("FAIL post_reset_count got %0d exp 0", word_count); end
  endtask

  task automatic test_streaming();
    bit ok; int derr, lerr, idle_cyc;
    do_reset();
    for (int i = 0; i < 128; i++) fifo_mem[i] = 16'(i);
    f_wr = 128; bus.out_ready = 1'b1; en = 1'b1;
    run_until(128, 300, 1'b0, ok);
    derr = 0; lerr = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== 16'(i)) derr++;
      if (rx_last[i] !== (i == 63 || i == 127)) lerr++;
    end
    tests++; if (!ok || rx_data.size() != 128) begin failed++; $display("FAIL stream_count got %0d exp 128", rx_data.size()); end
    tests++; if (derr != 0) begin failed++; $display("FAIL stream_data errors got %0d exp 0", derr); end
    tests++; if (lerr != 0) begin failed++; $display("FAIL stream_last errors got %0d exp 0", lerr); end
    tests++; if (first_xfer_cyc != 4) begin failed++; $display("FAIL stream_latency got %0d exp 4", first_xfer_cyc); end
    tests++; if (last_xfer_cyc - first_xfer_cyc != 127) begin failed++; $display("FAIL stream_rate got %0d exp 127", last_xfer_cyc - first_xfer_cyc); end
    tests++; if (word_count !== 32'd128) begin failed++; $display("FAIL stream_word_count got %0d exp 128", word_count); end
    drain_idle(ok, idle_cyc);
    tests++; if (!ok) begin failed++; $display("FAIL stream_idle got busy exp idle"); end
  endtask

  task automatic test_backpressure();
    bit ok; int derr, lerr, idle_cyc;
    do_reset();
    for (int i = 0; i < 200; i++) fifo_mem[i] = 16'hA000 + 16'(i);
    f_wr = 200; en = 1'b1;
    run_until(200, 2000, 1'b1, ok);
    derr = 0; lerr = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== 16'hA000 + 16'(i)) derr++;
      if (rx_last[i] !== (i == 63 || i == 127 || i == 191)) lerr++;
    end
    tests++; if (!ok || rx_data.size() != 200) begin failed++; $display("FAIL bp_count got %0d exp 200", rx_data.size()); end
    tests++; if (derr != 0) begin failed++; $display("FAIL bp_data errors got %0d exp 0", derr); end
    tests++; if (lerr != 0) begin failed++; $display("FAIL bp_last errors got %0d exp 0", lerr); end
    tests++; if (viol_over != 0) begin failed++; $display("FAIL bp_rd_when_full got %0d exp 0", viol_over); end
    tests++; if (viol_stable != 0) begin failed++; $display("FAIL bp_stall_stable got %0d exp 0", viol_stable); end
    tests++; if (word_count !== 32'd200) begin failed++; $display("FAIL bp_word_count got %0d exp 200", word_count); end
    drain_idle(ok, idle_cyc);
  endtask

  task automatic test_short_drain();
    bit ok; int derr, lerr, idle_cyc;
    do_reset();
    for (int i = 0; i < 77; i++) fifo_mem[i] = 16'h0100 + 16'(i);
    f_wr = 77; bus.out_ready = 1'b1; en = 1'b1;
    run_until(10, 100, 1'b0, ok);
    bus.out_ready = 1'b0;
    step();
    bus.out_ready = 1'b1;
    drain_idle(ok, idle_cyc);
    tests++; if (!ok || rx_data.size() != 13) begin failed++; $display("FAIL drain_count got %0d exp 13", rx_data.size()); end
    tests++; if (f_wr - f_rd != 64) begin failed++; $display("FAIL drain_no_fetch left got %0d exp 64", f_wr - f_rd); end
    tests++; if (idle_cyc != last_xfer_cyc + 1) begin failed++; $display("FAIL drain_busy_drop got %0d exp %0d", idle_cyc, last_xfer_cyc + 1); end
    en = 1'b1;
    run_until(77, 300, 1'b0, ok);
    derr = 0; lerr = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== 16'h0100 + 16'(i)) derr++;
      if (rx_last[i] !== (i == 12 || i == 76)) lerr++;
    end
    tests++; if (!ok || rx_data.size() != 77) begin failed++; $display("FAIL drain2_count got %0d exp 77", rx_data.size()); end
    tests++; if (derr != 0) begin failed++; $display("FAIL drain_data errors got %0d exp 0", derr); end
    tests++; if (lerr != 0) begin failed++; $display("FAIL drain_last errors got %0d exp 0", lerr); end
    drain_idle(ok, idle_cyc);
  endtask

  task automatic test_starvation();
    bit ok; int derr, lerr, idle_cyc;
    do_reset();
    for (int i = 0; i < 20; i++) fifo_mem[i] = 16'h0200 + 16'(i);
    f_wr = 20; bus.out_ready = 1'b1; en = 1'b1;
    run_until(20, 100, 1'b0, ok);
    repeat (50) step();
    tests++; if (rx_data.size() != 20 || busy !== 1'b1) begin failed++; $display("FAIL starve_hold got %0d/%b exp 20/1", rx_data.size(), busy); end
    for (int i = 20; i < 80; i++) fifo_mem[i] = 16'h0200 + 16'(i);
    f_wr = 80;
    run_until(80, 300, 1'b0, ok);
    derr = 0; lerr = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== 16'h0200 + 16'(i)) derr++;
      if (rx_last[i] !== (i == 63)) lerr++;
    end
    tests++; if (!ok || rx_data.size() != 80) begin failed++; $display("FAIL starve_count got %0d exp 80", rx_data.size()); end
    tests++; if (derr != 0) begin failed++; $display("FAIL starve_data errors got %0d exp 0", derr); end
    tests++; if (lerr != 0) begin failed++; $display("FAIL starve_last errors got %0d exp 0", lerr); end
    drain_idle(ok, idle_cyc);
  endtask

  task automatic test_reenable();
    bit ok; int derr, lerr, idle_cyc;
    do_reset();
    for (int i = 0; i < 100; i++) fifo_mem[i] = 16'h0300 + 16'(i);
    f_wr = 100; bus.out_ready = 1'b1; en = 1'b1;
    run_until(30, 100, 1'b0, ok);
    en = 1'b0;
    step();
    en = 1'b1;
    run_until(100, 300, 1'b0, ok);
    derr = 0; lerr = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== 16'h0300 + 16'(i)) derr++;
      if (rx_last[i] !== (i == 63)) lerr++;
    end
    tests++; if (!ok || rx_data.size() != 100) begin failed++; $display("FAIL reen_count got %0d exp 100", rx_data.size()); end
    tests++; if (derr != 0) begin failed++; $display("FAIL reen_data errors got %0d exp 0", derr); end
    tests++; if (lerr != 0) begin failed++; $display("FAIL reen_last errors got %0d exp 0", lerr); end
    tests++; if (busy_low_cnt != 1) begin failed++; $display("FAIL reen_busy_low got %0d exp 1", busy_low_cnt); end
    tests++; if (word_count !== 32'd100) begin failed++; $display("FAIL reen_word_count got %0d exp 100", word_count); end
    drain_idle(ok, idle_cyc);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    f_wr = 0;
    clear_log();
    test_reset();
    test_streaming();
    test_backpressure();
    test_short_drain();
    test_starvation();
    test_reenable();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
